// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux arbiter slice.
// Holds arbitration mode codes and the select-index width helper.
package arb_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Width of a channel index; never below one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// One-hot request grant, fixed priority or round-robin from ptr.
// Ports: req (requests), ptr (rr start), mode (1=rr), grant, idx.
module rr_grant
    import arb_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sel_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx
);

    int   w_base;
    int   w_j;
    logic w_found;

    // Scan from the start point, wrapping, and keep the first hit.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        w_base  = mode ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            w_j = (w_base + k) % N;
            if (!w_found && req[w_j]) begin
                w_found    = 1'b1;
                grant[w_j] = 1'b1;
                idx        = SW'(w_j);
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrating mux with a one-entry registered output stage.
// Ports: clk, rst_n, in_data/in_valid/in_ready, out_data/out_valid/out_ready, out_sel.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int size     = 32,
    parameter int channels = 4,
    parameter int mode     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [channels*size-1:0]   in_data,
    input  logic [channels-1:0]        in_valid,
    output logic [channels-1:0]        in_ready,
    output logic [size-1:0]            out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [sel_w(channels)-1:0] out_sel
);

    localparam int SW = sel_w(channels);

    logic [size-1:0]     r_data;
    logic [SW-1:0]       r_sel;
    logic                r_valid;
    logic [SW-1:0]       r_ptr;

    logic [channels-1:0] w_grant;
    logic [SW-1:0]       w_idx;
    logic                w_accept;
    logic                w_xfer;
    logic [SW-1:0]       w_ptr_nxt;
    logic                w_rr;

    assign w_rr = (mode == MODE_RR);

    rr_grant #(
        .N  (channels),
        .SW (SW)
    ) u_grant (
        .req   (in_valid),
        .ptr   (r_ptr),
        .mode  (w_rr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    // Register is free when empty or being drained this cycle.
    assign w_accept  = ~r_valid | out_ready;
    assign in_ready  = w_grant & {channels{w_accept}};
    assign w_xfer    = w_accept & (|in_valid);
    assign w_ptr_nxt = (w_idx == SW'(channels - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_data  <= in_data[w_idx*size +: size];
            r_sel   <= w_idx;
            r_valid <= 1'b1;
            if (w_rr) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench: round-robin and fixed-priority arb_mux instances
// driven with shared inputs and compared against a queue-free reference model.
module tb_arb_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;

    logic [3:0]  rr_ready, fp_ready;
    logic [3:0]  rr_data, fp_data;
    logic        rr_valid, fp_valid;
    logic [1:0]  rr_sel, fp_sel;

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = round-robin, 1 = fixed priority.
    logic       mv[2];
    logic [3:0] md[2];
    logic [1:0] ms[2];
    int         mp[2];
    logic [3:0] e_rdy[2];
    logic [3:0] s_rdy[2];
    int         mg[2];
    logic       ma[2];

    always #5 clk = ~clk;

    arb_mux #(.size(4), .channels(4), .mode(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_ready), .out_data(rr_data), .out_valid(rr_valid),
        .out_ready(out_ready), .out_sel(rr_sel)
    );

    arb_mux #(.size(4), .channels(4), .mode(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fp_ready), .out_data(fp_data), .out_valid(fp_valid),
        .out_ready(out_ready), .out_sel(fp_sel)
    );

    // First requesting channel, scanning from p (rr) or from 0 (fixed).
    function automatic int pick(input logic [3:0] v, input int p, input bit rr);
        for (int k = 0; k < 4; k++) begin
            if (v[((rr ? p : 0) + k) % 4]) return ((rr ? p : 0) + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset;
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; md[d] = '0; ms[d] = '0; mp[d] = 0;
        end
    endtask

    // Sample ready before the edge, advance one clock, update the model.
    task automatic tick;
        #1;
        for (int d = 0; d < 2; d++) begin
            mg[d] = pick(in_valid, mp[d], d == 0);
            ma[d] = !mv[d] || out_ready;
            e_rdy[d] = (ma[d] && mg[d] >= 0) ? 4'(1 << mg[d]) : 4'h0;
        end
        s_rdy[0] = rr_ready;
        s_rdy[1] = fp_ready;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                mv[d] = 1'b0; md[d] = '0; ms[d] = '0; mp[d] = 0;
            end else if (ma[d] && mg[d] >= 0) begin
                md[d] = in_data[mg[d]*4 +: 4];
                ms[d] = 2'(mg[d]);
                mv[d] = 1'b1;
                if (d == 0) mp[d] = (mg[d] + 1) % 4;
            end else if (out_ready) begin
                mv[d] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 4'h0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #3;
        checks++;
        if ({rr_valid, rr_data, rr_sel, fp_valid, fp_data, fp_sel} !== 14'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0",
                     {rr_valid, rr_data, rr_sel, fp_valid, fp_data, fp_sel});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (rr_valid !== 1'b0 || fp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b%b want 00", rr_valid, fp_valid);
        end
    endtask

    task automatic test_single;
        in_data = 16'h0A00; in_valid = 4'b0100; out_ready = 1'b1;
        tick();
        checks++;
        if (s_rdy[0] !== 4'b0100 || s_rdy[1] !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b/%b want 0100", s_rdy[0], s_rdy[1]);
        end
        checks++;
        if (rr_valid !== 1'b1 || rr_data !== 4'hA || rr_sel !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got v%b d%h s%0d want v1 dA s2",
                     rr_valid, rr_data, rr_sel);
        end
        checks++;
        if (fp_valid !== 1'b1 || fp_data !== 4'hA || fp_sel !== 2'd2) begin
            errors++;
            $display("FAIL single_out_fp: got v%b d%h s%0d want v1 dA s2",
                     fp_valid, fp_data, fp_sel);
        end
    endtask

    task automatic test_reset_midstream;
        in_valid = 4'b1111; in_data = 16'h4321; out_ready = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({rr_valid, rr_data, rr_sel, fp_valid, fp_data, fp_sel} !== 14'h0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0",
                     {rr_valid, rr_data, rr_sel, fp_valid, fp_data, fp_sel});
        end
        tick();
        checks++;
        if (s_rdy[0] !== 4'b0001 || rr_valid !== 1'b0 || fp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: got rdy %b v%b%b want 0001 v00",
                     s_rdy[0], rr_valid, fp_valid);
        end
        rst_n = 1'b1; in_valid = 4'h0;
        tick();
        checks++;
        if (rr_valid !== 1'b0 || fp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: got v%b%b want 00", rr_valid, fp_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_sel[5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'($urandom);
            tick();
            checks++;
            if (rr_sel !== exp_sel[i] || rr_valid !== 1'b1 || rr_data !== md[0]) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got s%0d v%b d%h want s%0d v1 d%h",
                         i, rr_sel, rr_valid, rr_data, exp_sel[i], md[0]);
            end
        end
    endtask

    task automatic test_fixed;
        in_valid = 4'b1010; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'($urandom);
            tick();
            checks++;
            if (fp_sel !== 2'd1 || s_rdy[1][3] !== 1'b0 || fp_data !== in_data[7:4]) begin
                errors++;
                $display("FAIL fixed[%0d]: got s%0d rdy%b d%h want s1 rdy0x1x d%h",
                         i, fp_sel, s_rdy[1], fp_data, in_data[7:4]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] held;
        in_valid = 4'b0001; in_data = 16'h0007; out_ready = 1'b1;
        tick();
        held = rr_data;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'($urandom);
            tick();
            checks++;
            if (rr_data !== held || rr_valid !== 1'b1 || s_rdy[0] !== 4'h0 ||
                s_rdy[1] !== 4'h0 || fp_data !== 4'h7) begin
                errors++;
                $display("FAIL stall[%0d]: got d%h v%b rdy%b/%b want d%h v1 rdy0",
                         i, rr_data, rr_valid, s_rdy[0], s_rdy[1], held);
            end
        end
        out_ready = 1'b1; in_data = 16'h0005;
        tick();
        checks++;
        if (s_rdy[0] !== 4'b0001 || rr_data !== 4'h5 || rr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got rdy%b d%h v%b want 0001 d5 v1",
                     s_rdy[0], rr_data, rr_valid);
        end
    endtask

    task automatic test_wrap;
        rst_n = 1'b0;
        #1;
        model_reset();
        in_valid = 4'h0;
        tick();
        rst_n = 1'b1;
        in_valid = 4'b0100; in_data = 16'h0C00; out_ready = 1'b1;
        tick();
        in_valid = 4'b0001; in_data = 16'h000B;
        tick();
        checks++;
        if (s_rdy[0] !== 4'b0001 || rr_sel !== 2'd0 || rr_valid !== 1'b1 ||
            rr_data !== 4'hB) begin
            errors++;
            $display("FAIL wrap: got rdy%b s%0d v%b d%h want 0001 s0 v1 dB",
                     s_rdy[0], rr_sel, rr_valid, rr_data);
        end
        in_valid = 4'b1111;
        tick();
        checks++;
        if (s_rdy[0] !== 4'b0010 || rr_sel !== 2'd1) begin
            errors++;
            $display("FAIL wrap_ptr: got rdy%b s%0d want 0010 s1", s_rdy[0], rr_sel);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (s_rdy[d] !== e_rdy[d] ||
                    (d == 0 ? {rr_valid, rr_data, rr_sel} : {fp_valid, fp_data, fp_sel})
                        !== {mv[d], md[d], ms[d]}) begin
                    errors++;
                    $display("FAIL rand[%0d] dut%0d: got rdy%b out%h want rdy%b out%h",
                             i, d, s_rdy[d],
                             (d == 0 ? {rr_valid, rr_data, rr_sel} :
                                       {fp_valid, fp_data, fp_sel}),
                             e_rdy[d], {mv[d], md[d], ms[d]});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_midstream();
        test_round_robin();
        test_fixed();
        test_backpressure();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
